lcd_slideshow_display: RTL and testbench

//  Parametrised 1-bpp image display controller for the SPI LCD path. Streams NUM_IMAGES packed

---
 rtl/lcd_slideshow_display.sv | 192 +++++++++++++++++++
 tb/tb_lcd_slideshow_display.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_slideshow_display.sv
// rtl/lcd_slideshow_display.sv - 1-bpp ROM image slideshow feeding the SPI LCD write path
//
// Purpose: passes lcd_init words through until init_done, then streams the selected
// packed mono image from a synchronous ROM as RGB332 pixel words (dc=1). Debounced
// next/prev keys and an optional auto-advance choose the image, and the choice is
// applied only at a frame boundary.
//
// Ports:
//   clk_25MHz, rst_n                  clock, asynchronous active-low reset
//   key_next, key_prev                raw keys (press = 1)
//   auto_mode                         advance every SLIDE_FRAMES frames
//   fg_color, bg_color                RGB332 colours for ROM bit 1 / bit 0
//   init_data, init_en_write          word and write enable from lcd_init
//   init_done                         lcd_init finished (level)
//   wr_done                           lcd_write finished the current word (pulse)
//   data, en_write                    word and write enable to lcd_write
//   rom_image_id, rom_addr, rom_data  image ROM interface (1-cycle read latency)
//   current_image_id                  image being drawn
//   display_active                    high in DISPLAY
//   frame_done                        pulse after the last pixel of a frame
module lcd_slideshow_display #(
  parameter int H_RES        = 240,
  parameter int V_RES        = 160,
  parameter int NUM_IMAGES   = 5,
  parameter int ID_W         = 3,
  parameter int ROM_ADDR_W   = 13,
  parameter int DEBOUNCE_CYC = 250000,
  parameter int SLIDE_FRAMES = 10
) (
  input  logic                  clk_25MHz,
  input  logic                  rst_n,
  input  logic                  key_next,
  input  logic                  key_prev,
  input  logic                  auto_mode,
  input  logic [7:0]            fg_color,
  input  logic [7:0]            bg_color,
  input  logic [8:0]            init_data,
  input  logic                  init_en_write,
  input  logic                  init_done,
  input  logic                  wr_done,
  output logic [8:0]            data,
  output logic                  en_write,
  output logic [ID_W-1:0]       rom_image_id,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  logic [7:0]            rom_data,
  output logic [ID_W-1:0]       current_image_id,
  output logic                  display_active,
  output logic                  frame_done
);

  localparam int P_W   = ROM_ADDR_W + 3;
  localparam int X_W   = $clog2(H_RES);
  localparam int Y_W   = $clog2(V_RES);
  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int F_W   = $clog2(SLIDE_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, INIT, DISPLAY} state_t;

  state_t          state;
  logic [8:0]      data_r;
  logic [X_W-1:0]  x;
  logic [Y_W-1:0]  y;
  logic [P_W-1:0]  p;
  logic [2:0]      sel_q;
  logic [ID_W-1:0] pending;
  logic [F_W-1:0]  fcnt;

  // index 0 = next, index 1 = prev
  logic [1:0]       key_raw, sync1, sync2, deb, req;
  logic [CNT_W-1:0] cnt [2];

  logic            advance, last_pix, frame_end, auto_fire, man_any, step_up, step_dn;
  logic [ID_W-1:0] pend_next;
  logic            pix_bit;

  assign key_raw      = {key_prev, key_next};
  assign rom_addr     = p[P_W-1:3];
  assign rom_image_id = current_image_id;
  // sel_q lags p by one cycle so it lines up with the ROM's registered output
  assign pix_bit      = rom_data[3'd7 - sel_q];

  always_comb begin
    data = data_r;
    if (display_active) data = {1'b1, pix_bit ? fg_color : bg_color};
  end

  always_comb begin
    advance   = (state == DISPLAY) && wr_done;
    last_pix  = (x == X_W'(H_RES - 1)) && (y == Y_W'(V_RES - 1));
    frame_end = advance && last_pix;
    man_any   = req[0] | req[1];
    auto_fire = auto_mode && frame_end && (fcnt == F_W'(SLIDE_FRAMES - 1));
    // simultaneous next+prev cancel; any manual request overrides auto
    step_up   = (req[0] & ~req[1]) | (auto_fire & ~man_any);
    step_dn   = req[1] & ~req[0];
    pend_next = pending;
    if (step_up)
      pend_next = (pending == ID_W'(NUM_IMAGES - 1)) ? '0 : pending + ID_W'(1);
    else if (step_dn)
      pend_next = (pending == '0) ? ID_W'(NUM_IMAGES - 1) : pending - ID_W'(1);
  end

  // Key debounce: the level only moves after DEBOUNCE_CYC consecutive differing samples;
  // req pulses once when the accepted level goes high.
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      req   <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        req[i] <= 1'b0;
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_W'(DEBOUNCE_CYC - 1)) begin
          cnt[i] <= '0;
          deb[i] <= sync2[i];
          req[i] <= sync2[i];
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      data_r           <= '0;
      en_write         <= 1'b0;
      display_active   <= 1'b0;
      x                <= '0;
      y                <= '0;
      p                <= '0;
      sel_q            <= '0;
      frame_done       <= 1'b0;
      pending          <= '0;
      fcnt             <= '0;
      current_image_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          state    <= INIT;
          en_write <= 1'b0;
          data_r   <= '0;
        end
        INIT: begin
          data_r   <= init_data;
          en_write <= init_en_write;
          if (init_done) begin
            state          <= DISPLAY;
            en_write       <= 1'b1;
            display_active <= 1'b1;
          end
        end
        DISPLAY: en_write <= 1'b1;
        default: state <= IDLE;
      endcase

      // Pixel scan; p is the running linear index so no multiply is needed.
      sel_q      <= p[2:0];
      frame_done <= frame_end;
      if (frame_end) begin
        x <= '0;
        y <= '0;
        p <= '0;
      end else if (advance) begin
        p <= p + P_W'(1);
        if (x == X_W'(H_RES - 1)) begin
          x <= '0;
          y <= y + Y_W'(1);
        end else begin
          x <= x + X_W'(1);
        end
      end

      pending <= pend_next;
      // new id lands together with frame_done so the next frame's first ROM read uses it
      if (frame_end) current_image_id <= pend_next;

      if (!auto_mode || man_any)
        fcnt <= '0;
      else if (frame_end)
        fcnt <= (fcnt == F_W'(SLIDE_FRAMES - 1)) ? '0 : fcnt + F_W'(1);
    end
  end

endmodule

// File: tb/tb_lcd_slideshow_display.sv
// tb/tb_lcd_slideshow_display.sv - self-checking bench for lcd_slideshow_display
module tb_lcd_slideshow_display;

  localparam int H = 16, V = 4, N = 5, IDW = 3, AW = 3, DEB = 8, SLIDE = 2;
  localparam int NPIX = H * V;
  localparam int LIMIT = 2000;

  logic           clk_25MHz = 1'b0;
  logic           rst_n = 1'b0;
  logic           key_next = 1'b0, key_prev = 1'b0, auto_mode = 1'b0;
  logic [7:0]     fg_color = 8'hE0, bg_color = 8'h03;
  logic [8:0]     init_data = '0;
  logic           init_en_write = 1'b0, init_done = 1'b0, wr_done = 1'b0;
  logic [8:0]     data;
  logic           en_write;
  logic [IDW-1:0] rom_image_id, current_image_id;
  logic [AW-1:0]  rom_addr;
  logic [7:0]     rom_data = '0;
  logic           display_active, frame_done;

  lcd_slideshow_display #(
    .H_RES(H), .V_RES(V), .NUM_IMAGES(N), .ID_W(IDW), .ROM_ADDR_W(AW),
    .DEBOUNCE_CYC(DEB), .SLIDE_FRAMES(SLIDE)
  ) dut (
    .clk_25MHz(clk_25MHz), .rst_n(rst_n), .key_next(key_next), .key_prev(key_prev),
    .auto_mode(auto_mode), .fg_color(fg_color), .bg_color(bg_color),
    .init_data(init_data), .init_en_write(init_en_write), .init_done(init_done),
    .wr_done(wr_done), .data(data), .en_write(en_write), .rom_image_id(rom_image_id),
    .rom_addr(rom_addr), .rom_data(rom_data), .current_image_id(current_image_id),
    .display_active(display_active), .frame_done(frame_done)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  logic [7:0] rom_mem [N][8];
  always @(posedge clk_25MHz) rom_data <= rom_mem[rom_image_id][rom_addr];

  int checks = 0, passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [8:0] exp_pix(input int id, input int k);
    logic [7:0] b;
    b = rom_mem[id][k / 8];
    return {1'b1, b[7 - (k % 8)] ? fg_color : bg_color};
  endfunction

  // lcd_write model plus frame-level reference: pixel k of the frame must be bit k of the
  // current image; ids follow pending requests and auto-advance at frame ends.
  int         k = 0, m_cur = 0, m_pend = 0, m_fcnt = 0, frame_errs = 0, wcnt = 0;
  bit         was_sent = 0, was_last = 0, cap_en = 1;
  logic [8:0] first_words [4];

  initial begin : lcd_model
    forever begin
      @(negedge clk_25MHz);
      if (!rst_n) begin
        k = 0; m_cur = 0; m_pend = 0; m_fcnt = 0; frame_errs = 0; wcnt = 0;
        was_sent = 0; wr_done = 1'b0; cap_en = 1;
      end else begin
        if (was_sent) begin
          was_sent = 0;
          if (frame_done !== was_last) frame_errs++;
          if (was_last) begin
            if (auto_mode) begin
              m_fcnt++;
              if (m_fcnt == SLIDE) begin
                m_fcnt = 0;
                m_pend = (m_pend + 1) % N;
              end
            end else begin
              m_fcnt = 0;
            end
            m_cur = m_pend;
            check("frame_pixel_errors", frame_errs, 0);
            check("frame_current_id", current_image_id, m_cur);
            check("frame_rom_id", rom_image_id, m_cur);
            frame_errs = 0;
            cap_en = 0;
          end
        end
        wr_done = 1'b0;
        if (display_active && en_write) begin
          wcnt++;
          if (wcnt == 4) begin
            wcnt = 0;
            if (cap_en && k < 4) first_words[k] = data;
            if (data !== exp_pix(m_cur, k)) frame_errs++;
            was_last = (k == NPIX - 1);
            k = was_last ? 0 : k + 1;
            wr_done = 1'b1;
            was_sent = 1;
          end
        end else begin
          wcnt = 0;
        end
      end
    end
  end

  task automatic wait_frame();
    int t = 0;
    do begin
      @(negedge clk_25MHz);
      t++;
    end while (frame_done !== 1'b1 && t < LIMIT);
    check("wait_frame_in_time", (t < LIMIT), 1);
    @(negedge clk_25MHz);
  endtask

  task automatic press(input bit nxt, input bit prv, input bit bounce);
    if (bounce) begin
      for (int i = 0; i < 5; i++) begin
        if (nxt) key_next = ~key_next;
        if (prv) key_prev = ~key_prev;
        repeat (3) @(negedge clk_25MHz);
      end
    end
    if (nxt) key_next = 1'b1;
    if (prv) key_prev = 1'b1;
    repeat (DEB * 3) @(negedge clk_25MHz);
    key_next = 1'b0;
    key_prev = 1'b0;
    repeat (DEB + 6) @(negedge clk_25MHz);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"}, data, 0);
    check({tag, "_en_write"}, en_write, 0);
    check({tag, "_rom_addr"}, rom_addr, 0);
    check({tag, "_rom_image_id"}, rom_image_id, 0);
    check({tag, "_current_id"}, current_image_id, 0);
    check({tag, "_display_active"}, display_active, 0);
    check({tag, "_frame_done"}, frame_done, 0);
  endtask

  task automatic do_init(input string tag);
    int errs = 0;
    logic [8:0] d;
    logic e;
    repeat (2) @(negedge clk_25MHz);
    for (int i = 0; i < 50; i++) begin
      d = 9'($urandom);
      e = 1'($urandom);
      init_data = d;
      init_en_write = e;
      @(negedge clk_25MHz);
      if (en_write !== e || data !== d) errs++;
    end
    check({tag, "_init_passthrough_errors"}, errs, 0);
    check({tag, "_inactive_during_init"}, display_active, 0);
    init_done = 1'b1;
    repeat (2) @(negedge clk_25MHz);
    check({tag, "_display_within_2"}, display_active, 1);
  endtask

  task automatic check_first_words(input string tag);
    logic [8:0] exp4 [4];
    exp4 = '{9'h1E0, 9'h103, 9'h1E0, 9'h103};
    for (int i = 0; i < 4; i++) check($sformatf("%s_word%0d", tag, i), first_words[i], exp4[i]);
  endtask

  typedef struct {
    bit bounce;
    int n_next;
    int n_prev;
    bit both;
    int exp_id;
  } vec_t;

  vec_t vecs [5];

  initial begin : main
    int prev_id, rn, rp, base, exp;
    vecs[0] = '{0, 0, 1, 0, 4};
    vecs[1] = '{0, 3, 0, 0, 2};
    vecs[2] = '{0, 0, 0, 1, 2};
    vecs[3] = '{1, 1, 0, 0, 3};
    vecs[4] = '{0, 1, 2, 0, 2};
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 8; j++) rom_mem[i][j] = 8'($urandom);
    rom_mem[0][0] = 8'hA0;

    rst_n = 1'b0;
    repeat (3) @(negedge clk_25MHz);
    check_all_zero("reset");
    rst_n = 1'b1;
    do_init("first");

    wait_frame();
    check_first_words("first");

    prev_id = 0;
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].both) begin
        press(1, 1, 0);
      end else begin
        for (int j = 0; j < vecs[v].n_next; j++) press(1, 0, vecs[v].bounce && j == 0);
        for (int j = 0; j < vecs[v].n_prev; j++) press(0, 1, 0);
      end
      check($sformatf("vec%0d_hold_until_frame", v), current_image_id, prev_id);
      if (!vecs[v].both) m_pend = (m_pend + vecs[v].n_next - vecs[v].n_prev + N) % N;
      m_fcnt = 0;
      wait_frame();
      check($sformatf("vec%0d_id", v), current_image_id, vecs[v].exp_id);
      prev_id = vecs[v].exp_id;
    end

    for (int r = 0; r < 6; r++) begin
      fg_color = 8'($urandom);
      bg_color = 8'($urandom);
      rn = $urandom_range(0, 2);
      rp = $urandom_range(0, 1);
      exp = (prev_id + rn - rp + N) % N;
      while (rn + rp > 0) begin
        if (rp == 0 || (rn > 0 && $urandom_range(0, 1) == 1)) begin
          press(1, 0, 1'($urandom));
          rn--;
        end else begin
          press(0, 1, 0);
          rp--;
        end
      end
      m_pend = exp;
      m_fcnt = 0;
      wait_frame();
      check($sformatf("rand%0d_id", r), current_image_id, exp);
      prev_id = exp;
    end

    base = prev_id;
    auto_mode = 1'b1;
    for (int f = 1; f <= 10; f++) begin
      wait_frame();
      check($sformatf("auto_frame%0d_id", f), current_image_id, (base + f / SLIDE) % N);
    end
    auto_mode = 1'b0;

    fg_color = 8'hE0;
    bg_color = 8'h03;
    repeat (100) @(negedge clk_25MHz);
    rst_n = 1'b0;
    init_done = 1'b0;
    #1;
    check_all_zero("midframe_reset");
    repeat (3) @(negedge clk_25MHz);
    rst_n = 1'b1;
    do_init("replay");
    wait_frame();
    check_first_words("replay");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
